// File: rtl/inst_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Optional feature: define INST_ARB_RR_EN for round-robin arbitration.
package inst_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdCap,
        StRdDone
    } state_e;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_e;

endpackage

// File: rtl/inst_arb_sel.sv
// Grant selection between the I2C write port and the fetch read port.
// With INST_ARB_RR_EN defined, ties go to the side not granted last;
// otherwise a write always wins and no last-grant input exists.
module inst_arb_sel
    import inst_arb_pkg::*;
(
    input  logic i_wr_elig,
    input  logic i_rd_elig,
`ifdef INST_ARB_RR_EN
    input  gnt_e i_last_gnt,
`endif
    output logic o_gnt_vld,
    output gnt_e o_gnt
);

    // Pick a winner among the eligible requests.
    always_comb begin
        o_gnt_vld = i_wr_elig | i_rd_elig;
        o_gnt     = GNT_RD;
`ifdef INST_ARB_RR_EN
        if (i_wr_elig && (!i_rd_elig || (i_last_gnt == GNT_RD))) begin
            o_gnt = GNT_WR;
        end
`else
        if (i_wr_elig) begin
            o_gnt = GNT_WR;
        end
`endif
    end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Arbitrates a single-port instruction memory between byte writes (I2C
// programming path) and word fetches. Reads are blocked in programming mode.
// Optional feature: define INST_ARB_RR_EN for round-robin on simultaneous requests.
module inst_mem_arbiter
    import inst_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_prog_mode,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_mem_cs,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wr_elig, rd_elig;
    logic              gnt_vld;
    gnt_e              gnt;

    assign wr_elig = i_wr_req;
    assign rd_elig = i_rd_req & ~i_prog_mode;

`ifdef INST_ARB_RR_EN
    gnt_e last_gnt_q, last_gnt_d;

    // Remember the winner of every grant taken in IDLE.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if ((state_q == StIdle) && gnt_vld) begin
            last_gnt_d = gnt;
        end
    end

    // Last-grant register; reset favours the write side on the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_gnt_q <= GNT_RD;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    inst_arb_sel u_sel (
        .i_wr_elig  (wr_elig),
        .i_rd_elig  (rd_elig),
`ifdef INST_ARB_RR_EN
        .i_last_gnt (last_gnt_q),
`endif
        .o_gnt_vld  (gnt_vld),
        .o_gnt      (gnt)
    );

    // Next-state logic and memory/handshake outputs for each state.
    always_comb begin
        state_d     = state_q;
        rd_data_d   = rd_data_q;
        o_mem_cs    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_wr_ack    = 1'b0;
        o_rd_valid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_vld) begin
                    state_d = (gnt == GNT_WR) ? StWr : StRd;
                end
            end
            StWr: begin
                o_mem_cs    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = i_wr_addr;
                o_mem_wdata = i_wr_data;
                o_wr_ack    = 1'b1;
                state_d     = StIdle;
            end
            StRd: begin
                o_mem_cs   = 1'b1;
                o_mem_addr = i_rd_addr;
                state_d    = StRdCap;
            end
            StRdCap: begin
                // Memory has one cycle of read latency; capture its output now.
                o_mem_cs   = 1'b1;
                o_mem_addr = i_rd_addr;
                rd_data_d  = i_mem_rdata;
                state_d    = StRdDone;
            end
            StRdDone: begin
                o_rd_valid = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and read-data registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign o_rd_data = rd_data_q;
    assign o_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Self-checking bench for inst_mem_arbiter (both INST_ARB_RR_EN settings).
module tb_inst_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst, i_prog_mode, i_wr_req, i_rd_req;
    logic [AW-1:0] i_wr_addr, i_rd_addr;
    logic [7:0]    i_wr_data;
    logic          o_wr_ack, o_rd_valid, o_mem_cs, o_mem_we, o_busy;
    logic [DW-1:0] o_rd_data, i_mem_rdata;
    logic [AW-1:0] o_mem_addr;
    logic [7:0]    o_mem_wdata;

    logic [DW-1:0] rom [256];
    int            n_tests = 0;
    int            n_fail = 0;
    bit            m_last_rd = 1'b1;

    inst_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_prog_mode (i_prog_mode),
        .i_wr_req    (i_wr_req),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .o_wr_ack    (o_wr_ack),
        .i_rd_req    (i_rd_req),
        .i_rd_addr   (i_rd_addr),
        .o_rd_valid  (o_rd_valid),
        .o_rd_data   (o_rd_data),
        .o_mem_cs    (o_mem_cs),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous memory with one cycle of read latency; garbage when not read.
    always @(posedge i_clk) begin
        if (o_mem_cs && !o_mem_we) i_mem_rdata <= rom[o_mem_addr];
        else                       i_mem_rdata <= $urandom();
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Arbitration policy for a tie, in terms of the model's last grant.
    function automatic bit pick_wr(input bit ew, input bit er);
`ifdef INST_ARB_RR_EN
        return ew && (!er || m_last_rd);
`else
        return ew;
`endif
    endfunction

    // Transaction-level model: times are negedge indices after the request is raised.
    task automatic model_txn(input bit do_wr, input bit do_rd, input int pm,
                             output int ewr, output int erd);
        int t;
        bit pw, pr, er;
        t = 0; pw = do_wr; pr = do_rd; ewr = -1; erd = -1;
        while (pw || pr) begin
            er = pr && (t >= pm);
            if (!pw && !er) begin
                t = pm;
            end else if (pick_wr(pw, er)) begin
                ewr = t + 1; t = t + 2; pw = 0; m_last_rd = 0;
            end else begin
                erd = t + 3; t = t + 4; pr = 0; m_last_rd = 1;
            end
        end
    endtask

    // Raise the requested transactions, follow the handshakes, observe the bus.
    task automatic run_txn(input bit do_wr, input logic [7:0] waddr, input logic [7:0] wdata,
                           input bit do_rd, input logic [7:0] raddr, input int pm,
                           input int pm_up, output int wr_t, output int rd_t,
                           output logic [31:0] rd_val, output int busy_n, output int acks,
                           output int valids, output int bus_err, output logic [7:0] ack_addr,
                           output logic [7:0] ack_wdata);
        int drain;
        drain = 0; wr_t = -1; rd_t = -1; rd_val = '0; busy_n = 0; acks = 0; valids = 0;
        bus_err = 0; ack_addr = '0; ack_wdata = '0;
        @(negedge i_clk);
        i_wr_addr = waddr; i_wr_data = wdata; i_rd_addr = raddr;
        i_wr_req = do_wr; i_rd_req = do_rd; i_prog_mode = (pm > 0);
        for (int t = 1; t <= 200 && drain < 4; t++) begin
            @(negedge i_clk);
            busy_n += int'(o_busy);
            if (!o_mem_cs && (o_mem_we || o_mem_addr !== '0 || o_mem_wdata !== '0)) bus_err++;
            if (o_mem_cs && o_mem_we && (o_mem_addr !== waddr || o_mem_wdata !== wdata)) bus_err++;
            if (o_mem_cs && !o_mem_we && o_mem_addr !== raddr) bus_err++;
            if (o_wr_ack) begin
                acks++;
                if (wr_t < 0) begin
                    wr_t = t; ack_addr = o_mem_addr; ack_wdata = o_mem_wdata; i_wr_req = 0;
                    if (!(o_mem_cs && o_mem_we)) bus_err++;
                end
            end
            if (o_rd_valid) begin
                valids++;
                if (rd_t < 0) begin
                    rd_t = t; rd_val = o_rd_data; i_rd_req = 0;
                end
            end
            if (pm > 0 && t == pm) i_prog_mode = 0;
            if (pm_up > 0 && t == pm_up) i_prog_mode = 1;
            if (!i_wr_req && !i_rd_req) drain++;
        end
        i_wr_req = 0; i_rd_req = 0; i_prog_mode = 0;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst = 1; i_wr_req = 0; i_rd_req = 0; i_prog_mode = 1'($urandom_range(0, 1));
        i_wr_addr = 8'($urandom()); i_wr_data = 8'($urandom()); i_rd_addr = 8'($urandom());
        repeat (2) @(negedge i_clk);
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        n_tests++; if (o_wr_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", o_wr_ack); end
        n_tests++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_rd_valid); end
        n_tests++; if (o_rd_data !== '0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", o_rd_data); end
        n_tests++; if (o_mem_cs !== 1'b0 || o_mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_cs_we: got %b%b want 00", o_mem_cs, o_mem_we); end
        n_tests++; if (o_mem_addr !== '0 || o_mem_wdata !== '0) begin n_fail++; $display("FAIL rst_bus: got %h/%h want 0/0", o_mem_addr, o_mem_wdata); end
        i_rst = 0; i_prog_mode = 0; m_last_rd = 1;
    endtask

    // Simultaneous requests right after reset: the write must win first.
    task automatic test_simultaneous();
        int wr_t, rd_t, busy_n, acks, valids, bus_err, ewr, erd;
        logic [31:0] rd_val; logic [7:0] aa, ad;
        model_txn(1, 1, 0, ewr, erd);
        run_txn(1, 8'h11, 8'h3C, 1, 8'h22, 0, 0, wr_t, rd_t, rd_val, busy_n, acks, valids, bus_err, aa, ad);
        n_tests++; if (wr_t !== ewr) begin n_fail++; $display("FAIL sim_wr_time: got %0d want %0d", wr_t, ewr); end
        n_tests++; if (rd_t !== erd) begin n_fail++; $display("FAIL sim_rd_time: got %0d want %0d", rd_t, erd); end
        n_tests++; if (rd_val !== rom[8'h22]) begin n_fail++; $display("FAIL sim_rd_data: got %h want %h", rd_val, rom[8'h22]); end
        n_tests++; if (bus_err !== 0) begin n_fail++; $display("FAIL sim_bus: got %0d errors want 0", bus_err); end
    endtask

    task automatic test_write_basic();
        int wr_t, rd_t, busy_n, acks, valids, bus_err, ewr, erd;
        logic [31:0] rd_val; logic [7:0] aa, ad;
        model_txn(1, 0, 0, ewr, erd);
        run_txn(1, 8'h10, 8'hA5, 0, 8'h00, 0, 0, wr_t, rd_t, rd_val, busy_n, acks, valids, bus_err, aa, ad);
        n_tests++; if (wr_t !== 1) begin n_fail++; $display("FAIL wr_latency: got %0d want 1", wr_t); end
        n_tests++; if (aa !== 8'h10) begin n_fail++; $display("FAIL wr_addr: got %h want 10", aa); end
        n_tests++; if (ad !== 8'hA5) begin n_fail++; $display("FAIL wr_wdata: got %h want a5", ad); end
        n_tests++; if (acks !== 1) begin n_fail++; $display("FAIL wr_ack_count: got %0d want 1", acks); end
        n_tests++; if (busy_n !== 1) begin n_fail++; $display("FAIL wr_busy: got %0d want 1", busy_n); end
        n_tests++; if (bus_err !== 0) begin n_fail++; $display("FAIL wr_bus: got %0d errors want 0", bus_err); end
    endtask

    task automatic test_read_basic();
        int wr_t, rd_t, busy_n, acks, valids, bus_err, ewr, erd;
        logic [31:0] rd_val; logic [7:0] aa, ad;
        rom[8'h04] = 32'hDEADBEEF;
        model_txn(0, 1, 0, ewr, erd);
        run_txn(0, 8'h00, 8'h00, 1, 8'h04, 0, 0, wr_t, rd_t, rd_val, busy_n, acks, valids, bus_err, aa, ad);
        n_tests++; if (rd_t !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", rd_t); end
        n_tests++; if (rd_val !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd_val); end
        n_tests++; if (valids !== 1) begin n_fail++; $display("FAIL rd_valid_count: got %0d want 1", valids); end
        n_tests++; if (busy_n !== 3) begin n_fail++; $display("FAIL rd_busy: got %0d want 3", busy_n); end
        n_tests++; if (bus_err !== 0) begin n_fail++; $display("FAIL rd_bus: got %0d errors want 0", bus_err); end
        n_tests++; if (o_rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold: got %h want deadbeef", o_rd_data); end
    endtask

    task automatic test_prog_mode();
        int wr_t, rd_t, busy_n, acks, valids, bus_err, ewr, erd;
        logic [31:0] rd_val; logic [7:0] aa, ad;
        model_txn(0, 1, 10, ewr, erd);
        run_txn(0, 8'h00, 8'h00, 1, 8'h08, 10, 0, wr_t, rd_t, rd_val, busy_n, acks, valids, bus_err, aa, ad);
        n_tests++; if (rd_t !== 13) begin n_fail++; $display("FAIL pm_latency: got %0d want 13", rd_t); end
        n_tests++; if (busy_n !== 3) begin n_fail++; $display("FAIL pm_busy: got %0d want 3", busy_n); end
        n_tests++; if (rd_val !== rom[8'h08]) begin n_fail++; $display("FAIL pm_data: got %h want %h", rd_val, rom[8'h08]); end
        // Raising programming mode after the grant must not abort the read.
        model_txn(0, 1, 0, ewr, erd);
        run_txn(0, 8'h00, 8'h00, 1, 8'h09, 0, 1, wr_t, rd_t, rd_val, busy_n, acks, valids, bus_err, aa, ad);
        n_tests++; if (rd_t !== 3) begin n_fail++; $display("FAIL pm_midflight: got %0d want 3", rd_t); end
        n_tests++; if (rd_val !== rom[8'h09]) begin n_fail++; $display("FAIL pm_mid_data: got %h want %h", rd_val, rom[8'h09]); end
    endtask

    task automatic test_reset_mid_read();
        int wr_t, rd_t, busy_n, acks, valids, bus_err, ewr, erd;
        logic [31:0] rd_val; logic [7:0] aa, ad;
        rom[8'h33] = 32'h12345678;
        @(negedge i_clk);
        i_rd_addr = 8'h33; i_rd_req = 1; i_prog_mode = 0;
        repeat (2) @(negedge i_clk);
        n_tests++; if (o_mem_cs !== 1'b1) begin n_fail++; $display("FAIL rmr_in_cap: cs got %b want 1", o_mem_cs); end
        i_rst = 1;
        @(negedge i_clk);
        n_tests++; if (o_rd_data !== '0) begin n_fail++; $display("FAIL rmr_rdata: got %h want 0", o_rd_data); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rmr_busy: got %b want 0", o_busy); end
        n_tests++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_valid: got %b want 0", o_rd_valid); end
        i_rst = 0; i_rd_req = 0; m_last_rd = 1;
        @(negedge i_clk);
        n_tests++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_valid_late: got %b want 0", o_rd_valid); end
        model_txn(0, 1, 0, ewr, erd);
        run_txn(0, 8'h00, 8'h00, 1, 8'h33, 0, 0, wr_t, rd_t, rd_val, busy_n, acks, valids, bus_err, aa, ad);
        n_tests++; if (rd_t !== 3) begin n_fail++; $display("FAIL rmr_reissue_time: got %0d want 3", rd_t); end
        n_tests++; if (rd_val !== 32'h12345678) begin n_fail++; $display("FAIL rmr_reissue_data: got %h want 12345678", rd_val); end
    endtask

    task automatic test_back_to_back();
        bit ev_w[5], exp_w[5];
        int ev_t[5], exp_t[5];
        int n, t, bad_data;
        t = 0;
        for (int k = 0; k < 5; k++) begin
            exp_w[k] = (k < 4) ? pick_wr(1, 1) : 1'b0;
            if (exp_w[k]) begin exp_t[k] = t + 1; t = t + 2; m_last_rd = 0; end
            else begin exp_t[k] = t + 3; t = t + 4; m_last_rd = 1; end
        end
        n = 0; bad_data = 0;
        @(negedge i_clk);
        i_wr_addr = 8'h20; i_wr_data = 8'h5A; i_rd_addr = 8'h40;
        i_wr_req = 1; i_rd_req = 1; i_prog_mode = 0;
        for (int c = 1; c <= 100 && n < 5; c++) begin
            @(negedge i_clk);
            if (o_wr_ack) begin
                ev_w[n] = 1; ev_t[n] = c; n++;
            end else if (o_rd_valid) begin
                ev_w[n] = 0; ev_t[n] = c; n++;
                if (o_rd_data !== rom[8'h40]) bad_data++;
            end
            if (n >= 4) i_wr_req = 0;
            if (n >= 5) i_rd_req = 0;
        end
        i_wr_req = 0; i_rd_req = 0;
        repeat (3) @(negedge i_clk);
        n_tests++; if (n !== 5) begin n_fail++; $display("FAIL b2b_events: got %0d want 5", n); end
        for (int k = 0; k < n; k++) begin
            n_tests++; if (ev_w[k] !== exp_w[k]) begin n_fail++; $display("FAIL b2b_kind[%0d]: got wr=%b want wr=%b", k, ev_w[k], exp_w[k]); end
            n_tests++; if (ev_t[k] !== exp_t[k]) begin n_fail++; $display("FAIL b2b_time[%0d]: got %0d want %0d", k, ev_t[k], exp_t[k]); end
        end
        n_tests++; if (bad_data !== 0) begin n_fail++; $display("FAIL b2b_data: got %0d bad reads want 0", bad_data); end
    endtask

    task automatic test_random();
        int wr_t, rd_t, busy_n, acks, valids, bus_err, ewr, erd, pm;
        logic [31:0] rd_val; logic [7:0] aa, ad, wa, wd, ra;
        bit do_wr, do_rd;
        for (int it = 0; it < 30; it++) begin
            do_wr = 1'($urandom_range(0, 1)); do_rd = 1'($urandom_range(0, 1));
            if (!do_wr && !do_rd) do_rd = 1;
            pm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0;
            wa = 8'($urandom()); wd = 8'($urandom()); ra = 8'($urandom());
            model_txn(do_wr, do_rd, pm, ewr, erd);
            run_txn(do_wr, wa, wd, do_rd, ra, pm, 0, wr_t, rd_t, rd_val, busy_n, acks, valids, bus_err, aa, ad);
            n_tests++; if (wr_t !== ewr) begin n_fail++; $display("FAIL rnd%0d_wr_time: got %0d want %0d", it, wr_t, ewr); end
            n_tests++; if (rd_t !== erd) begin n_fail++; $display("FAIL rnd%0d_rd_time: got %0d want %0d", it, rd_t, erd); end
            if (do_rd) begin
                n_tests++; if (rd_val !== rom[ra]) begin n_fail++; $display("FAIL rnd%0d_rd_data: got %h want %h", it, rd_val, rom[ra]); end
            end
            n_tests++; if (busy_n !== int'(do_wr) + 3 * int'(do_rd)) begin n_fail++; $display("FAIL rnd%0d_busy: got %0d want %0d", it, busy_n, int'(do_wr) + 3 * int'(do_rd)); end
            n_tests++; if (acks !== int'(do_wr) || valids !== int'(do_rd)) begin n_fail++; $display("FAIL rnd%0d_pulses: got %0d/%0d want %0d/%0d", it, acks, valids, do_wr, do_rd); end
            n_tests++; if (bus_err !== 0) begin n_fail++; $display("FAIL rnd%0d_bus: got %0d errors want 0", it, bus_err); end
        end
    endtask

    initial begin
        i_rst = 1; i_prog_mode = 0; i_wr_req = 0; i_rd_req = 0;
        i_wr_addr = '0; i_wr_data = '0; i_rd_addr = '0;
        for (int i = 0; i < 256; i++) rom[i] = $urandom();
        test_reset();
        test_simultaneous();
        test_write_basic();
        test_read_basic();
        test_prog_mode();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
